// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: op codes, FSM states and
// the per-cycle shift amount selection.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Bits to shift this cycle: never more than what remains, so count cannot wrap.
  function automatic logic [4:0] step_amt(input logic [4:0] cnt, input int unsigned step);
    if (cnt < 5'(step)) return cnt;
    return 5'(step);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift of 0..STEP bits; only the legal amounts are
// decoded, so no full 32-bit barrel shifter is built.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  op_e         op_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    for (int unsigned k = 1; k <= STEP; k++) begin
      if (amt_i == 5'(k)) begin
        case (op_i)
          OP_SLL:  data_o = data_i << k;
          OP_SRL:  data_o = data_i >> k;
          OP_SRA:  data_o = 32'($signed(data_i) >>> k);
          default: data_o = data_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: latches an operand on start, shifts STEP bits per
// cycle until the count is exhausted, then pulses done for one cycle.
module shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [31:0] shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  k;
  logic [31:0] step_out;
  logic        unused_shamt_hi;

  assign unused_shamt_hi = ^shamt[31:5];

  assign k = step_amt(cnt_q, STEP);

  shift_step #(.STEP(STEP)) u_step (
    .op_i   (op_q),
    .data_i (work_q),
    .amt_i  (k),
    .data_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = operand;
          op_d    = op_e'(op);
          cnt_d   = shamt[4:0];
          state_d = (shamt[4:0] == '0 || op_e'(op) == OP_RSVD) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - k;
        if (cnt_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come only from registers, so no input reaches them combinationally.
  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = work_q;

endmodule
